// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and types for the instruction fetch stage.
//   XLEN           default address/data width
//   DEPTH          default fetch window (in flight + buffered)
//   NOP            canonical no-op encoding (addi x0,x0,0), handy for stimulus
//   fetch_entry_t  {pc, instr, fault} as presented to decode
package fetch_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clr             synchronous clear (drops all contents), same effect as reset
//   push/push_data  write side
//   pop/pop_data    read side; pop_data is the head entry (undefined when empty)
//   full/empty      status
//   count           number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so DEPTH=1 works with a 1-bit pointer.
  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset || clr) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || clr) !(pop && empty));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly after the pc register.
// Issues in-order word reads to instruction memory, buffers the returned words
// with their pc, and hands them to decode. A flush discards everything buffered
// and marks every in-flight read to be dropped when it returns.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   pc, pc_req, pc_ack                 pc register interface (pc_ack = pc consumed)
//   flush                              redirect: drop buffered and in-flight fetches
//   imem_req_valid/ready/addr          memory request channel (word aligned address)
//   imem_rsp_valid/data                in-order responses, no backpressure
//   instr_valid/ready, instr,
//   instr_pc, instr_fault              decode interface
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned pc is not fetched; once the
// stage is idle it is delivered straight to decode as a faulting entry.
module fetch_unit import fetch_pkg::*; #(
  parameter int DEPTH = fetch_pkg::DEPTH,
  parameter int XLEN  = fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_req,
  output logic            pc_ack,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } entry_t;

  // outstanding counts every issued-but-unanswered read, including the ones
  // that will be thrown away; drop counts how many of those are stale.
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;

  logic            credit;
  logic            req_ok;
  logic            fault_push;
  logic            fire;
  logic            rsp_take;
  logic            rsp_drop;

  logic [XLEN-1:0] pcq_head;
  logic            pcq_full;
  logic            pcq_empty;
  logic [CW-1:0]   pcq_count;

  entry_t          iq_in;
  entry_t          iq_head;
  logic            iq_push;
  logic            iq_pop;
  logic            iq_full;
  logic            iq_empty;
  logic [CW-1:0]   iq_count;

  assign credit = ({1'b0, outstanding} + {1'b0, iq_count}) < (CW + 1)'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic aligned;
  assign aligned    = (pc[1:0] == 2'b00);
  assign req_ok     = aligned;
  // Only once nothing is in flight, so the fault entry lands behind every
  // older instruction and cannot collide with a response push.
  assign fault_push = ~reset & pc_req & ~aligned & ~flush & (outstanding == '0) & ~iq_full;
`else
  assign req_ok     = 1'b1;
  assign fault_push = 1'b0;
`endif

  assign imem_req_valid = ~reset & pc_req & credit & ~flush & req_ok;
  assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign fire           = imem_req_valid & imem_req_ready;
  assign pc_ack         = fire | fault_push;

  assign rsp_take = imem_rsp_valid & ~flush & (drop == '0);
  assign rsp_drop = imem_rsp_valid & ~flush & (drop != '0);

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) pc_q (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .push      (fire),
    .push_data (pc),
    .pop       (rsp_take),
    .pop_data  (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  always_comb begin
    iq_in = '0;
    if (rsp_take) begin
      iq_in.pc    = pcq_head;
      iq_in.instr = imem_rsp_data;
      iq_in.fault = 1'b0;
    end else begin
      iq_in.pc    = pc;
      iq_in.instr = 32'h0;
      iq_in.fault = 1'b1;
    end
  end

  assign iq_push = rsp_take | fault_push;
  assign iq_pop  = instr_valid & instr_ready & ~flush;

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) instr_q (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .push      (iq_push),
    .push_data (iq_in),
    .pop       (iq_pop),
    .pop_data  (iq_head),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  // Storage is not reset, so hold the outputs at zero while the queue is empty.
  assign instr_valid = ~iq_empty;
  assign instr       = iq_empty ? 32'h0 : iq_head.instr;
  assign instr_pc    = iq_empty ? '0 : iq_head.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign instr_fault = ~iq_empty & iq_head.fault;
  logic unused_sig;
  assign unused_sig = ^{pcq_full, pcq_empty, pcq_count};
`else
  assign instr_fault = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{pcq_full, pcq_empty, pcq_count, iq_full, iq_head.fault};
`endif

  // A response in the flush cycle still retires one outstanding read; all
  // remaining reads become stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
      if (flush)         drop <= outstanding - CW'(imem_rsp_valid);
      else if (rsp_drop) drop <= drop - 1'b1;
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && outstanding == '0));

endmodule
